// File: rtl/round_robin_arbiter_pkg.sv
// Shared types and the round-robin selection function for the arbiter.
package arbiter_pkg;

    typedef enum logic {ARB_IDLE, ARB_OWNED} ArbState_t;

    // Widest requester vector rr_next accepts; callers zero-extend into it.
    localparam int ARB_MAX_SIZE = 64;

    // Index of the first set req scanning last+1, last+2, ... (mod size).
    // Scanning from the far end lets the nearest hit overwrite, so no early exit is needed.
    // Returns last when nothing is requesting.
    function automatic int rr_next(input int last, input logic [ARB_MAX_SIZE-1:0] req,
                                   input int size);
        int idx;
        rr_next = last;
        for (int off = size; off >= 1; off--) begin
            idx = last + off;
            if (idx >= size) idx = idx - size;
            if (req[idx]) rr_next = idx;
        end
    endfunction

endpackage

// File: rtl/round_robin_arbiter_if.sv
// Requester-side bus of the round-robin arbiter: request lines in, grant/select/status out.
interface round_robin_arbiter_if #(
    parameter int SIZE = 2
);
    logic [SIZE-1:0]         req;
    logic [SIZE-1:0]         grant;
    logic [$clog2(SIZE)-1:0] select;
    logic                    busy;
    logic                    timeout;

    modport master (output req, input grant, input select, input busy, input timeout);
    modport slave  (input req, output grant, output select, output busy, output timeout);
endinterface

// File: rtl/round_robin_arbiter_picker.sv
// Combinational rotated priority encoder: picks the next requester after last_i.
module rr_picker
    import arbiter_pkg::*;
#(
    parameter int SIZE  = 2,
    parameter int IDX_W = $clog2(SIZE)
) (
    input  logic [SIZE-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             valid_o
);
    logic [ARB_MAX_SIZE-1:0] req_ext;

    assign req_ext  = ARB_MAX_SIZE'(req_i);
    assign winner_o = IDX_W'(rr_next(int'(last_i), req_ext, SIZE));
    assign valid_o  = |req_i;
endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: one owner at a time, held until it drops req.
// Optional hold-limit watchdog enabled by defining ARB_WATCHDOG_EN.
module round_robin_arbiter
    import arbiter_pkg::*;
#(
    parameter int SIZE     = 2,
    parameter int MAX_HOLD = 16
) (
    input logic                    clk,
    input logic                    reset,
    round_robin_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(SIZE);

    if (SIZE < 2 || MAX_HOLD < 2) begin : g_param_chk
        $error("round_robin_arbiter: SIZE and MAX_HOLD must both be >= 2");
    end

    ArbState_t        state_q, state_d;
    logic [SIZE-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0] select_q, select_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             timeout_q, timeout_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic             owner_req;

    rr_picker #(.SIZE(SIZE), .IDX_W(IDX_W)) u_picker (
        .req_i    (bus.req),
        .last_i   (last_q),
        .winner_o (pick_idx),
        .valid_o  (pick_vld)
    );

    // select always names the owner while in ARB_OWNED.
    assign owner_req = bus.req[select_q];

`ifdef ARB_WATCHDOG_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              hold_limit;
    // hold_q counts owned cycles already completed; the edge ending cycle MAX_HOLD is the limit.
    assign hold_limit = (hold_q == HOLD_W'(MAX_HOLD - 1));
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        select_d  = select_q;
        last_d    = last_q;
        timeout_d = 1'b0;
`ifdef ARB_WATCHDOG_EN
        hold_d    = hold_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    select_d          = pick_idx;
                    state_d           = ARB_OWNED;
`ifdef ARB_WATCHDOG_EN
                    hold_d            = '0;
`endif
                end
            end
            ARB_OWNED: begin
                if (!owner_req) begin
                    grant_d = '0;
                    last_d  = select_q;
                    state_d = ARB_IDLE;
`ifdef ARB_WATCHDOG_EN
                end else if (hold_limit) begin
                    grant_d   = '0;
                    last_d    = select_q;
                    state_d   = ARB_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
`endif
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            select_q  <= '0;
            last_q    <= IDX_W'(SIZE - 1);
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            select_q  <= select_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef ARB_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hold_q <= '0;
        else       hold_q <= hold_d;
    end
`endif

    assign bus.grant   = grant_q;
    assign bus.select  = select_q;
    assign bus.busy    = |grant_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_round_robin_arbiter.sv
// Scoreboard bench for round_robin_arbiter (SIZE=4, MAX_HOLD=8); follows ARB_WATCHDOG_EN.
module tb_round_robin_arbiter;
    localparam int SIZE     = 4;
    localparam int MAX_HOLD = 8;
`ifdef ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    typedef struct {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       to;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    // reference model state
    bit   m_owned;
    int   m_owner, m_last, m_sel, m_held;

    round_robin_arbiter_if #(.SIZE(SIZE)) bus ();

    round_robin_arbiter #(.SIZE(SIZE), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owned = 1'b0;
        m_owner = 0;
        m_last  = SIZE - 1;
        m_sel   = 0;
        m_held  = 0;
    endtask

    // Advance the model by one rising edge with request vector r and queue the outcome.
    task automatic model_step(input logic [3:0] r);
        exp_t e;
        int   k;
        e.to = 1'b0;
        if (!m_owned) begin
            if (r != 4'b0) begin
                k = 1;
                while (!r[(m_last + k) % SIZE]) k++;
                m_owner = (m_last + k) % SIZE;
                m_sel   = m_owner;
                m_owned = 1'b1;
                m_held  = 0;
            end
        end else begin
            m_held++;
            if (!r[m_owner]) begin
                m_owned = 1'b0;
                m_last  = m_owner;
            end else if (WD && m_held == MAX_HOLD) begin
                m_owned = 1'b0;
                m_last  = m_owner;
                e.to    = 1'b1;
            end
        end
        e.grant = m_owned ? 4'(1 << m_owner) : 4'b0;
        e.sel   = 2'(m_sel);
        e.busy  = m_owned;
        sb_q.push_back(e);
    endtask

    // One cycle: drive req at negedge, expect after the edge, compare 1 ns after it.
    task automatic drive(input logic [3:0] r);
        exp_t e;
        @(negedge clk);
        bus.req = r;
        model_step(r);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("grant",   32'(bus.grant),   32'(e.grant));
            chk("select",  32'(bus.select),  32'(e.sel));
            chk("busy",    32'(bus.busy),    32'(e.busy));
            chk("timeout", 32'(bus.timeout), 32'(e.to));
        end
        chk("inv_onehot0", 32'($onehot0(bus.grant)), 32'd1);
        chk("inv_busy", 32'(bus.busy), 32'(|bus.grant));
        if (bus.grant != 4'b0) chk("inv_sel", 32'(bus.grant[bus.select]), 32'd1);
    endtask

    // Reset asserted between edges; outputs must clear with no clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_grant",   32'(bus.grant),   32'd0);
        chk("rst_select",  32'(bus.select),  32'd0);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        bus.req = 4'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin : guard
        #200000;
        $display("FAIL sim_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int to_cnt;
        reset   = 1'b1;
        bus.req = 4'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // single request, held
        for (int i = 0; i < 4; i++) begin
            drive(4'b0001);
            chk("single_grant", 32'(bus.grant), 32'h1);
        end

        // reset while owned
        do_reset();

        // rotation: each owner holds two cycles then drops for one
        for (int i = 0; i < 5; i++) begin
            drive(4'hF);
            chk("rot_order", 32'(bus.grant), 32'(1 << (i % SIZE)));
            drive(4'hF);
            drive(4'hF & ~4'(1 << (i % SIZE)));
            chk("rot_dead", 32'(bus.grant), 32'h0);
        end

        // lone re-request by requester 2
        do_reset();
        repeat (3) drive(4'b0100);
        drive(4'b0000);
        chk("lone_dead", 32'(bus.grant), 32'h0);
        chk("lone_sel_dead", 32'(bus.select), 32'd2);
        repeat (3) begin
            drive(4'b0100);
            chk("lone_regrant", 32'(bus.grant), 32'h4);
            chk("lone_sel", 32'(bus.select), 32'd2);
        end

        // watchdog: requester 1 holds req for 20 cycles
        do_reset();
        to_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            drive(4'b0010);
            if (bus.timeout) to_cnt++;
        end
        chk("wd_pulses", 32'(to_cnt), WD ? 32'd2 : 32'd0);
        drive(4'b0000);

        // contention: req[3] rises under owner 0, then owner 0 drops
        do_reset();
        repeat (2) drive(4'b0001);
        repeat (2) drive(4'b1001);
        chk("cont_hold", 32'(bus.grant), 32'h1);
        drive(4'b1000);
        chk("cont_dead", 32'(bus.grant), 32'h0);
        drive(4'b1000);
        chk("cont_grant", 32'(bus.grant), 32'h8);
        chk("cont_sel", 32'(bus.select), 32'd3);

        // random traffic against the model
        for (int i = 0; i < 60; i++) drive(4'($urandom_range(0, 15)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
